// File: rtl/instr_decoder_pkg.sv
// Shared definitions for the instruction decoder: the ALU op encoding
// (op_name), the decoder FSM states and the decoded micro-op record.
package instr_decoder_pkg;

  // Default geometry of an instruction word and of the register file.
  localparam int P_IW    = 9;
  localparam int P_RW    = 3;
  localparam int P_CNT_W = 16;

  // ALU operation names; opcodes 000..110 map 1:1 onto these.
  typedef logic [2:0] op_name;

  localparam op_name kADD = 3'b000;
  localparam op_name kLSH = 3'b001;
  localparam op_name kRSH = 3'b010;
  localparam op_name kXOR = 3'b011;
  localparam op_name kAND = 3'b100;
  localparam op_name kSUB = 3'b101;
  localparam op_name kCLR = 3'b110;
  // Opcode of the two-word load-immediate; never appears as an ALU op.
  localparam op_name kLDI = 3'b111;

  // IDLE decodes words normally; WAIT_IMM treats the next word as raw data.
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_IMM = 1'b1
  } dec_state_e;

  // One decoded micro-op as handed to execute.
  typedef struct packed {
    op_name            alu_op;
    logic [P_RW-1:0]   rd;
    logic [P_RW-1:0]   rs;
    logic [P_IW-1:0]   imm;
    logic              is_ldi;
    logic              illegal;
  } uop_t;

  // Harmless micro-op (ADD r0,r0, no immediate): reset value and the
  // base that every decode path starts from.
  function automatic uop_t uop_nop();
    uop_t u;
    u.alu_op  = kADD;
    u.rd      = '0;
    u.rs      = '0;
    u.imm     = '0;
    u.is_ldi  = 1'b0;
    u.illegal = 1'b0;
    return u;
  endfunction

endpackage

// File: rtl/instr_decoder_if.sv
// Fetch-side and execute-side handshake bundle of the instruction decoder.
//
// Handshake rules for both channels: a transfer happens on a rising clock
// edge where valid and ready are both 1. A producer holding valid=1 keeps
// its payload stable until that transfer; ready may be given or withheld
// at any time and never depends on the payload.
interface instr_decoder_if
  #(
    parameter int IW = 9,
    parameter int RW = 3
  );
  import instr_decoder_pkg::*;

  // fetch -> decoder
  logic          in_valid;
  logic          in_ready;
  logic [IW-1:0] instr;

  // decoder -> execute
  logic          out_valid;
  logic          out_ready;
  op_name        alu_op;
  logic [RW-1:0] rd;
  logic [RW-1:0] rs;
  logic [IW-1:0] imm;
  logic          is_ldi;
  logic          illegal;

  // Environment view: drives instructions in, consumes micro-ops.
  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, alu_op, rd, rs, imm, is_ldi, illegal
  );

  // Decoder view.
  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, alu_op, rd, rs, imm, is_ldi, illegal
  );

endinterface

// File: rtl/instr_decoder_opcode_lut.sv
// Combinational decode of a single instruction word. Produces the
// micro-op for the one-word ops and flags the start of a load-immediate.
// Malformed LDI words (non-zero rs field) become an illegal no-op.
module instr_decoder_opcode_lut
  import instr_decoder_pkg::*;
  #(
    parameter int IW = P_IW
  )
  (
    input  logic [IW-1:0] instr,
    output uop_t          uop,
    output logic          ldi_start
  );

  op_name opcode;

  // Table lookup from opcode to micro-op fields.
  always_comb begin
    uop       = uop_nop();
    ldi_start = 1'b0;
    opcode    = instr[IW-1 -: 3];

    if (opcode == kLDI) begin
      if (instr[2:0] == 3'b000) begin
        // First half of LDI: nothing to emit yet.
        ldi_start = 1'b1;
      end else begin
        // Leaves alu_op=ADD, rd=rs=0 so execute writes nothing back.
        uop.illegal = 1'b1;
      end
    end else begin
      uop.alu_op = opcode;
      uop.rd     = instr[5:3];
      // CLR has no source operand; ignore whatever the word carries.
      uop.rs     = (opcode == kCLR) ? 3'b000 : instr[2:0];
    end
  end

endmodule

// File: rtl/instr_decoder.sv
// Instruction decoder front end: accepts words from fetch, assembles the
// two-word LDI, and presents one registered micro-op at a time to execute.
// Also counts micro-ops handed over (wrapping) and exposes its FSM state.
module instr_decoder
  import instr_decoder_pkg::*;
  #(
    parameter int IW    = P_IW,
    parameter int RW    = P_RW,
    parameter int CNT_W = P_CNT_W
  )
  (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               flush,
    instr_decoder_if.slave     bus,
    output logic [CNT_W-1:0]   uop_count,
    output dec_state_e         dbg_state
  );

  // Registered state.
  dec_state_e        state_q,       state_d;
  logic              out_valid_q,   out_valid_d;
  uop_t              uop_q,         uop_d;
  logic [RW-1:0]     ldi_rd_q,      ldi_rd_d;
  logic [CNT_W-1:0]  uop_count_q,   uop_count_d;

  // Handshake terms.
  logic in_ready;
  logic in_fire;
  logic out_fire;

  // Single-word decode of the incoming word.
  uop_t lut_uop;
  logic lut_ldi_start;

  instr_decoder_opcode_lut #(
    .IW (IW)
  ) u_opcode_lut (
    .instr     (bus.instr),
    .uop       (lut_uop),
    .ldi_start (lut_ldi_start)
  );

  // Accept only when the output slot is free or is being emptied on this
  // edge; a flush or reset cycle never accepts.
  always_comb begin
    in_ready = !Reset && !flush && (!out_valid_q || bus.out_ready);
    in_fire  = bus.in_valid && in_ready;
    out_fire = out_valid_q && bus.out_ready;
  end

  // Next-state logic: FSM, output register, LDI destination latch, counter.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    uop_d       = uop_q;
    ldi_rd_d    = ldi_rd_q;
    // A fire on a flush edge still counts, so the counter sits outside
    // the flush branch.
    uop_count_d = uop_count_q + {{(CNT_W-1){1'b0}}, out_fire};

    if (flush) begin
      // Drop the pending micro-op and any half-built LDI.
      out_valid_d = 1'b0;
      state_d     = IDLE;
    end else if (in_fire) begin
      case (state_q)
        IDLE: begin
          if (lut_ldi_start) begin
            ldi_rd_d = bus.instr[2*RW-1:RW];
            state_d  = WAIT_IMM;
          end else begin
            uop_d       = lut_uop;
            out_valid_d = 1'b1;
          end
        end
        WAIT_IMM: begin
          // The word is data, not an instruction: bypass the decode table.
          uop_d        = uop_nop();
          uop_d.rd     = ldi_rd_q;
          uop_d.imm    = bus.instr;
          uop_d.is_ldi = 1'b1;
          out_valid_d  = 1'b1;
          state_d      = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset also discards a
  // half-built LDI and wins over flush.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      uop_q       <= uop_nop();
      ldi_rd_q    <= '0;
      uop_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      uop_q       <= uop_d;
      ldi_rd_q    <= ldi_rd_d;
      uop_count_q <= uop_count_d;
    end
  end

  // Drive the interface and debug outputs straight from the registers.
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.alu_op    = uop_q.alu_op;
    bus.rd        = uop_q.rd;
    bus.rs        = uop_q.rs;
    bus.imm       = uop_q.imm;
    bus.is_ldi    = uop_q.is_ldi;
    bus.illegal   = uop_q.illegal;
    uop_count     = uop_count_q;
    dbg_state     = state_q;
  end

endmodule

// File: tb/tb_instr_decoder.sv
// Self-checking bench for instr_decoder: table of instruction vectors with
// expected micro-ops, hand sequences for stall/flush/reset, and a random
// stream under random back-pressure.
module tb_instr_decoder;
  import instr_decoder_pkg::*;

  localparam int W = 20;  // {alu_op, rd, rs, imm, is_ldi, illegal}

  logic        Clk;
  logic        Reset;
  logic        flush;
  logic [15:0] uop_count;
  dec_state_e  dbg_state;

  instr_decoder_if #(.IW(9), .RW(3)) bus ();

  instr_decoder dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .flush     (flush),
    .bus       (bus.slave),
    .uop_count (uop_count),
    .dbg_state (dbg_state)
  );

  int         checks = 0;
  int         errors = 0;
  int         fires  = 0;
  bit         rand_bp = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [8:0]   instr;
    bit           emits;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  // ---------------- clock ----------------
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] mk(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs, input logic [8:0] imm,
                                      input logic ldi, input logic ill);
    return {op, rd, rs, imm, ldi, ill};
  endfunction

  function automatic logic [W-1:0] act();
    return {bus.alu_op, bus.rd, bus.rs, bus.imm, bus.is_ldi, bus.illegal};
  endfunction

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, a, e);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  // Present one word and hold it until it is accepted; returns #1 after
  // the accepting edge.
  task automatic send(input logic [8:0] w);
    bit done;
    done = 0;
    bus.in_valid = 1'b1;
    bus.instr    = w;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge Clk);
      if (bus.in_ready) begin
        @(posedge Clk);
        #1;
        done = 1;
      end
    end
    bus.in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout word=%0h expected=accept", w);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  // A micro-op counts as handed over when valid&ready is seen ahead of the edge.
  always @(negedge Clk) begin
    if (!Reset && bus.out_valid && bus.out_ready) begin
      fires++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_uop actual=%0h expected=none", act());
      end else begin
        check("uop", act(), exp_q.pop_front());
      end
    end
  end

  // Random back-pressure during the random phase.
  always @(posedge Clk) begin
    if (rand_bp) begin
      #1;
      bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{9'b000_001_010, 1, mk(kADD, 3'd1, 3'd2, 9'h000, 0, 0)};
    vecs[1]  = '{9'b101_011_100, 1, mk(kSUB, 3'd3, 3'd4, 9'h000, 0, 0)};
    vecs[2]  = '{9'b110_101_111, 1, mk(kCLR, 3'd5, 3'd0, 9'h000, 0, 0)};
    vecs[3]  = '{9'b001_110_001, 1, mk(kLSH, 3'd6, 3'd1, 9'h000, 0, 0)};
    vecs[4]  = '{9'b010_000_111, 1, mk(kRSH, 3'd0, 3'd7, 9'h000, 0, 0)};
    vecs[5]  = '{9'b011_111_101, 1, mk(kXOR, 3'd7, 3'd5, 9'h000, 0, 0)};
    vecs[6]  = '{9'b100_010_011, 1, mk(kAND, 3'd2, 3'd3, 9'h000, 0, 0)};
    vecs[7]  = '{9'b111_010_000, 0, '0};
    vecs[8]  = '{9'h1A5,         1, mk(kADD, 3'd2, 3'd0, 9'h1A5, 1, 0)};
    vecs[9]  = '{9'b111_001_011, 1, mk(kADD, 3'd0, 3'd0, 9'h000, 0, 1)};
    vecs[10] = '{9'b000_100_011, 1, mk(kADD, 3'd4, 3'd3, 9'h000, 0, 0)};
    vecs[11] = '{9'b111_001_000, 0, '0};
    vecs[12] = '{9'b111_011_000, 1, mk(kADD, 3'd1, 3'd0, 9'h1D8, 1, 0)};

    bus.in_valid  = 1'b0;
    bus.instr     = '0;
    bus.out_ready = 1'b1;
    flush         = 1'b0;
    Reset         = 1'b1;

    // Reset state
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check("reset_in_ready", bus.in_ready, 0);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_payload", act(), mk(kADD, 0, 0, 0, 0, 0));
    check("reset_count", uop_count, 0);
    check("reset_state", dbg_state, IDLE);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // ADD then SUB streamed, one-cycle latency
    exp_q.push_back(mk(kADD, 3'd1, 3'd2, 9'h000, 0, 0));
    send(9'b000_001_010);
    check("add_valid", bus.out_valid, 1);
    check("add_op", bus.alu_op, kADD);
    exp_q.push_back(mk(kSUB, 3'd3, 3'd4, 9'h000, 0, 0));
    send(9'b101_011_100);
    check("sub_valid", bus.out_valid, 1);
    check("sub_op", bus.alu_op, kSUB);
    cycle(1);
    check("two_count", uop_count, 2);
    check("two_drained", bus.out_valid, 0);

    // Vector table
    foreach (vecs[i]) begin
      if (vecs[i].emits) exp_q.push_back(vecs[i].exp);
      send(vecs[i].instr);
      if (vecs[i].emits) begin
        check("vec_valid", bus.out_valid, 1);
        check("vec_state", dbg_state, IDLE);
      end else begin
        check("ldi_first_no_out", bus.out_valid, 0);
        check("ldi_first_state", dbg_state, WAIT_IMM);
      end
    end
    cycle(2);
    check("table_count", uop_count, fires[15:0]);

    // Back-pressure: micro-op held for 3 cycles
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(kXOR, 3'd1, 3'd6, 9'h000, 0, 0));
    send(9'b011_001_110);
    bus.in_valid = 1'b1;
    bus.instr    = 9'b000_010_010;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check("stall_valid", bus.out_valid, 1);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_payload", act(), mk(kXOR, 3'd1, 3'd6, 9'h000, 0, 0));
    end
    @(posedge Clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle(2);
    check("stall_released", bus.out_valid, 0);
    check("stall_queue", exp_q.size(), 0);
    check("stall_count", uop_count, fires[15:0]);

    // Random single-word ops under random back-pressure
    rand_bp = 1;
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op, rd, rs;
      op = 3'($urandom_range(0, 6));
      rd = 3'($urandom_range(0, 7));
      rs = 3'($urandom_range(0, 7));
      exp_q.push_back(mk(op, rd, (op == kCLR) ? 3'd0 : rs, 9'h000, 0, 0));
      send({op, rd, rs});
    end
    rand_bp = 0;
    @(posedge Clk);
    #2;
    bus.out_ready = 1'b1;
    cycle(3);
    check("rand_queue", exp_q.size(), 0);
    check("rand_count", uop_count, fires[15:0]);

    // Flush on the same edge as an output fire: the fire counts
    exp_q.push_back(mk(kAND, 3'd2, 3'd3, 9'h000, 0, 0));
    send(9'b100_010_011);
    flush = 1'b1;
    @(negedge Clk);
    check("flush_in_ready", bus.in_ready, 0);
    @(posedge Clk);
    #1;
    flush = 1'b0;
    check("flush_fire_valid", bus.out_valid, 0);
    check("flush_fire_count", uop_count, fires[15:0]);

    // Flush with a stalled micro-op: dropped, not counted
    bus.out_ready = 1'b0;
    exp_q.push_back(mk(kLSH, 3'd3, 3'd3, 9'h000, 0, 0));
    send(9'b001_011_011);
    flush = 1'b1;
    cycle(1);
    flush = 1'b0;
    bus.out_ready = 1'b1;
    void'(exp_q.pop_back());
    check("flush_drop_valid", bus.out_valid, 0);
    cycle(1);
    check("flush_drop_count", uop_count, fires[15:0]);

    // Flush after LDI first word: immediate decodes as CLR r4
    send(9'b111_010_000);
    check("flush_ldi_wait", dbg_state, WAIT_IMM);
    flush = 1'b1;
    cycle(1);
    flush = 1'b0;
    check("flush_ldi_valid", bus.out_valid, 0);
    check("flush_ldi_state", dbg_state, IDLE);
    exp_q.push_back(mk(kCLR, 3'd4, 3'd0, 9'h000, 0, 0));
    send(9'h1A5);
    check("flush_ldi_next", bus.alu_op, kCLR);
    cycle(2);
    check("pre_reset_count", uop_count, fires[15:0]);

    // Reset (with flush) after LDI first word
    send(9'b111_010_000);
    Reset = 1'b1;
    flush = 1'b1;
    cycle(1);
    check("rst_ldi_valid", bus.out_valid, 0);
    check("rst_ldi_state", dbg_state, IDLE);
    check("rst_ldi_count", uop_count, 0);
    check("rst_ldi_in_ready", bus.in_ready, 0);
    Reset = 1'b0;
    flush = 1'b0;
    fires = 0;
    exp_q.push_back(mk(kCLR, 3'd4, 3'd0, 9'h000, 0, 0));
    send(9'h1A5);
    check("rst_ldi_next", bus.alu_op, kCLR);
    cycle(2);
    check("final_queue", exp_q.size(), 0);
    check("final_count", uop_count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
